// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit
//   Control path for the SAD pipelined datapath. The ID-stage opcode is decoded
//   combinationally into a control bundle. That bundle then moves through the
//   ID/EX, EX/MEM and MEM/WB control registers. The block also detects hazards,
//   resolves branches in EX and steers the PC and IF/ID register.
//
// Build option:
//   PCU_FORWARD_EN  defined   -> ForwardA/B select the MEM (10) or WB (01)
//                                stage result. Only a load-use hazard stalls.
//                   undefined -> ForwardA/B are tied to 00. Any RAW hazard
//                                against a producer in EX or MEM stalls until
//                                that producer reaches WB.
//
// Ports:
//   Clk, Rst              rising-edge clock, synchronous active-low reset
//   ID_Opcode/Rs/Rt/Rd    fields of the instruction held in IF/ID
//   EX_Zero               ALU zero flag of the instruction in EX
//   PCWrite, IFIDWrite    PC and IF/ID enables (low while stalled)
//   IFIDFlush             zero IF/ID at the next edge
//   PCSrc, Jump           PC source selects (branch target, jump target)
//   EX_*                  EX-stage ALU controls
//   MEM_*                 MEM-stage memory enables
//   WB_*                  WB-stage write enable, result select, destination
//   ForwardA/B            ALU operand forward selects
module pipelined_control_unit #(
  parameter int ALUOP_W = 5,
  parameter int REG_W   = 5,
  parameter int OPC_W   = 6
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [OPC_W-1:0]   ID_Opcode,
  input  logic [REG_W-1:0]   ID_Rs,
  input  logic [REG_W-1:0]   ID_Rt,
  input  logic [REG_W-1:0]   ID_Rd,
  input  logic               EX_Zero,
  output logic               PCWrite,
  output logic               IFIDWrite,
  output logic               IFIDFlush,
  output logic               PCSrc,
  output logic               Jump,
  output logic [ALUOP_W-1:0] EX_ALUOp,
  output logic               EX_ALUSrc,
  output logic               EX_ZeroExt,
  output logic               MEM_MemRead,
  output logic               MEM_MemWrite,
  output logic               WB_RegWrite,
  output logic               WB_MemToReg,
  output logic [REG_W-1:0]   WB_WriteReg,
  output logic [1:0]         ForwardA,
  output logic [1:0]         ForwardB
);

  localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(6'b000000);
  localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(6'b001000);
  localparam logic [OPC_W-1:0] OP_MUL   = OPC_W'(6'b011100);
  localparam logic [OPC_W-1:0] OP_ANDI  = OPC_W'(6'b001100);
  localparam logic [OPC_W-1:0] OP_ORI   = OPC_W'(6'b001101);
  localparam logic [OPC_W-1:0] OP_XORI  = OPC_W'(6'b001110);
  localparam logic [OPC_W-1:0] OP_SLTI  = OPC_W'(6'b001010);
  localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(6'b100011);
  localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(6'b101011);
  localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'(6'b000100);
  localparam logic [OPC_W-1:0] OP_BNE   = OPC_W'(6'b000101);
  localparam logic [OPC_W-1:0] OP_J     = OPC_W'(6'b000010);

  localparam logic [ALUOP_W-1:0] ALU_RTYPE = ALUOP_W'(5'b00000);
  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(5'b00001);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(5'b00010);
  localparam logic [ALUOP_W-1:0] ALU_MUL   = ALUOP_W'(5'b00011);
  localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(5'b10100);
  localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(5'b10101);
  localparam logic [ALUOP_W-1:0] ALU_XOR   = ALUOP_W'(5'b11001);
  localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(5'b11101);

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               zero_ext;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic               mem_to_reg;
    logic               branch;
    logic               br_ne;
    logic [REG_W-1:0]   dst;
  } ex_ctrl_t;

  typedef struct packed {
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic               mem_to_reg;
    logic [REG_W-1:0]   dst;
  } mem_ctrl_t;

  typedef struct packed {
    logic               reg_write;
    logic               mem_to_reg;
    logic [REG_W-1:0]   dst;
  } wb_ctrl_t;

  ex_ctrl_t  id_ctrl;
  logic      id_reg_dst;
  logic      id_jump;

  ex_ctrl_t  ex_q;
  mem_ctrl_t mem_q;
  wb_ctrl_t  wb_q;

  logic      taken;
  logic      ex_hit;
  logic      load_use;
  logic      hazard;

  // ---------------------------------------------------------------------------
  // ID decode
  // ---------------------------------------------------------------------------
  always_comb begin
    id_ctrl    = '0;
    id_reg_dst = 1'b0;
    id_jump    = 1'b0;
    case (ID_Opcode)
      OP_RTYPE: begin
        id_ctrl.reg_write  = 1'b1;
        id_reg_dst         = 1'b1;
        id_ctrl.mem_to_reg = 1'b1;
        id_ctrl.alu_op     = ALU_RTYPE;
      end
      OP_ADDI: begin
        id_ctrl.reg_write  = 1'b1;
        id_ctrl.alu_src    = 1'b1;
        id_ctrl.mem_to_reg = 1'b1;
        id_ctrl.alu_op     = ALU_ADD;
      end
      OP_MUL: begin
        id_ctrl.reg_write  = 1'b1;
        id_reg_dst         = 1'b1;
        id_ctrl.mem_to_reg = 1'b1;
        id_ctrl.alu_op     = ALU_MUL;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        id_ctrl.reg_write  = 1'b1;
        id_ctrl.alu_src    = 1'b1;
        id_ctrl.mem_to_reg = 1'b1;
        id_ctrl.zero_ext   = 1'b1;
        if (ID_Opcode == OP_ANDI)
          id_ctrl.alu_op = ALU_AND;
        else if (ID_Opcode == OP_ORI)
          id_ctrl.alu_op = ALU_OR;
        else
          id_ctrl.alu_op = ALU_XOR;
      end
      OP_SLTI: begin
        id_ctrl.reg_write  = 1'b1;
        id_ctrl.alu_src    = 1'b1;
        id_ctrl.mem_to_reg = 1'b1;
        id_ctrl.alu_op     = ALU_SLT;
      end
      OP_LW: begin
        id_ctrl.reg_write = 1'b1;
        id_ctrl.alu_src   = 1'b1;
        id_ctrl.mem_read  = 1'b1;
        id_ctrl.alu_op    = ALU_ADD;
      end
      OP_SW: begin
        id_ctrl.alu_src   = 1'b1;
        id_ctrl.mem_write = 1'b1;
        id_ctrl.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        id_ctrl.branch = 1'b1;
        id_ctrl.alu_op = ALU_SUB;
      end
      OP_BNE: begin
        id_ctrl.branch = 1'b1;
        id_ctrl.br_ne  = 1'b1;
        id_ctrl.alu_op = ALU_SUB;
      end
      OP_J: begin
        // The jump acts in ID only; its bundle travels down the pipe as a NOP.
        id_jump = 1'b1;
      end
      default: ;
    endcase
    id_ctrl.dst = id_reg_dst ? ID_Rd : ID_Rt;
  end

  // ---------------------------------------------------------------------------
  // Hazard detection and branch resolution
  // ---------------------------------------------------------------------------
  assign taken    = ex_q.branch & (EX_Zero ^ ex_q.br_ne);
  assign ex_hit   = (ex_q.dst != '0) && ((ex_q.dst == ID_Rs) || (ex_q.dst == ID_Rt));
  assign load_use = ex_q.mem_read && ex_hit;

`ifdef PCU_FORWARD_EN
  logic [REG_W-1:0] ex_rs_q;
  logic [REG_W-1:0] ex_rt_q;

  assign hazard = load_use;

  always_comb begin
    ForwardA = 2'b00;
    ForwardB = 2'b00;
    if (mem_q.reg_write && (mem_q.dst != '0) && (mem_q.dst == ex_rs_q))
      ForwardA = 2'b10;
    else if (wb_q.reg_write && (wb_q.dst != '0) && (wb_q.dst == ex_rs_q))
      ForwardA = 2'b01;
    if (mem_q.reg_write && (mem_q.dst != '0) && (mem_q.dst == ex_rt_q))
      ForwardB = 2'b10;
    else if (wb_q.reg_write && (wb_q.dst != '0) && (wb_q.dst == ex_rt_q))
      ForwardB = 2'b01;
  end

  always_ff @(posedge Clk) begin
    if (!Rst || taken || hazard) begin
      ex_rs_q <= '0;
      ex_rt_q <= '0;
    end else begin
      ex_rs_q <= ID_Rs;
      ex_rt_q <= ID_Rt;
    end
  end
`else
  logic mem_hit;

  // Without forwarding the consumer waits in ID until the producer is in WB;
  // the register file writes before it reads, so that cycle is safe.
  assign mem_hit = (mem_q.dst != '0) && ((mem_q.dst == ID_Rs) || (mem_q.dst == ID_Rt));
  assign hazard  = load_use || (ex_q.reg_write && ex_hit) || (mem_q.reg_write && mem_hit);

  assign ForwardA = 2'b00;
  assign ForwardB = 2'b00;
`endif

  // Priority: taken branch, then stall, then jump. Everything is held low
  // while reset is asserted.
  always_comb begin
    PCWrite   = 1'b0;
    IFIDWrite = 1'b0;
    IFIDFlush = 1'b0;
    PCSrc     = 1'b0;
    Jump      = 1'b0;
    if (Rst) begin
      if (taken) begin
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IFIDFlush = 1'b1;
        PCSrc     = 1'b1;
      end else if (!hazard) begin
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        if (id_jump) begin
          Jump      = 1'b1;
          IFIDFlush = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      if (taken || hazard)
        ex_q <= '0;
      else
        ex_q <= id_ctrl;
      mem_q <= '{mem_read:   ex_q.mem_read,
                 mem_write:  ex_q.mem_write,
                 reg_write:  ex_q.reg_write,
                 mem_to_reg: ex_q.mem_to_reg,
                 dst:        ex_q.dst};
      wb_q  <= '{reg_write:  mem_q.reg_write,
                 mem_to_reg: mem_q.mem_to_reg,
                 dst:        mem_q.dst};
    end
  end

  assign EX_ALUOp     = ex_q.alu_op;
  assign EX_ALUSrc    = ex_q.alu_src;
  assign EX_ZeroExt   = ex_q.zero_ext;
  assign MEM_MemRead  = mem_q.mem_read;
  assign MEM_MemWrite = mem_q.mem_write;
  assign WB_RegWrite  = wb_q.reg_write;
  assign WB_MemToReg  = wb_q.mem_to_reg;
  assign WB_WriteReg  = wb_q.dst;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Testbench for pipelined_control_unit. A table of per-cycle vectors covers
// reset, decode of every opcode through all stages, jump and branch
// resolution. Hand-written sequences then cover load-use, RAW, branch-over-stall,
// jump-during-stall, forwarding and reset during a stall. Expectations for
// the PCU_FORWARD_EN build differ only where forwarding changes behaviour.
module tb_pipelined_control_unit;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_MUL  = 6'b011100;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_NOP  = 6'b111111;

`ifdef PCU_FORWARD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  logic       Clk = 1'b0;
  logic       Rst;
  logic [5:0] ID_Opcode;
  logic [4:0] ID_Rs, ID_Rt, ID_Rd;
  logic       EX_Zero;
  logic       PCWrite, IFIDWrite, IFIDFlush, PCSrc, Jump;
  logic [4:0] EX_ALUOp;
  logic       EX_ALUSrc, EX_ZeroExt, MEM_MemRead, MEM_MemWrite;
  logic       WB_RegWrite, WB_MemToReg;
  logic [4:0] WB_WriteReg;
  logic [1:0] ForwardA, ForwardB;

  pipelined_control_unit #(.ALUOP_W(5), .REG_W(5), .OPC_W(6)) dut (
    .Clk(Clk), .Rst(Rst),
    .ID_Opcode(ID_Opcode), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
    .EX_Zero(EX_Zero),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
    .PCSrc(PCSrc), .Jump(Jump),
    .EX_ALUOp(EX_ALUOp), .EX_ALUSrc(EX_ALUSrc), .EX_ZeroExt(EX_ZeroExt),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .WB_RegWrite(WB_RegWrite), .WB_MemToReg(WB_MemToReg), .WB_WriteReg(WB_WriteReg),
    .ForwardA(ForwardA), .ForwardB(ForwardB)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       pcw, ifw, flush, pcsrc, jump;
    logic [4:0] aluop;
    logic       asrc, zx, mrd, mwr, wrw, wmtr;
    logic [4:0] wreg;
    logic [1:0] fa, fb;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    logic       zero;
    outs_t      exp;
  } vec_t;

  localparam int NVEC = 22;
  vec_t  vecs[NVEC];
  outs_t got;
  int    checks = 0;
  int    failures = 0;

  assign got = {PCWrite, IFIDWrite, IFIDFlush, PCSrc, Jump, EX_ALUOp, EX_ALUSrc,
                EX_ZeroExt, MEM_MemRead, MEM_MemWrite, WB_RegWrite, WB_MemToReg,
                WB_WriteReg, ForwardA, ForwardB};

  function automatic outs_t mk(input logic pcw, ifw, fl, ps, j,
                               input logic [4:0] aop, input logic asrc, zx, mrd, mwr,
                               input logic wrw, wmtr, input logic [4:0] wreg);
    outs_t o;
    o = '{pcw, ifw, fl, ps, j, aop, asrc, zx, mrd, mwr, wrw, wmtr, wreg, 2'b00, 2'b00};
    return o;
  endfunction

  function automatic vec_t v(input logic r, input logic [5:0] op,
                             input logic [4:0] rs, rt, rd, input logic z, input outs_t e);
    vec_t x;
    x.rst = r; x.op = op; x.rs = rs; x.rt = rt; x.rd = rd; x.zero = z; x.exp = e;
    return x;
  endfunction

  // Inputs change just after the rising edge; outputs are sampled on the
  // falling edge of the same cycle.
  task automatic apply(input logic r, input logic [5:0] op,
                       input logic [4:0] rs, rt, rd, input logic z);
    @(posedge Clk);
    #1;
    Rst = r; ID_Opcode = op; ID_Rs = rs; ID_Rt = rt; ID_Rd = rd; EX_Zero = z;
    @(negedge Clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b0; ID_Opcode = OP_R; ID_Rs = '0; ID_Rt = '0; ID_Rd = '0; EX_Zero = 1'b0;

    //                 rst op       rs rt  rd zero   pcw ifw fl ps j  aluop     as zx mr mw rw mtr wreg
    vecs[0]  = v(1'b0, OP_R,    0, 0,  0, 0, mk(0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 0, 0));
    vecs[1]  = v(1'b0, OP_R,    0, 0,  0, 0, mk(0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 0, 0));
    vecs[2]  = v(1'b1, OP_NOP,  0, 0,  0, 0, mk(1, 1, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 0, 0));
    vecs[3]  = v(1'b1, OP_ADDI, 0, 5,  0, 0, mk(1, 1, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 0, 0));
    vecs[4]  = v(1'b1, OP_NOP,  0, 0,  0, 0, mk(1, 1, 0, 0, 0, 5'b00001, 1, 0, 0, 0, 0, 0, 0));
    vecs[5]  = v(1'b1, OP_NOP,  0, 0,  0, 0, mk(1, 1, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 0, 0));
    vecs[6]  = v(1'b1, OP_ANDI, 0, 6,  0, 0, mk(1, 1, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 1, 1, 5));
    vecs[7]  = v(1'b1, OP_ORI,  0, 7,  0, 0, mk(1, 1, 0, 0, 0, 5'b10100, 1, 1, 0, 0, 0, 0, 0));
    vecs[8]  = v(1'b1, OP_XORI, 0, 9,  0, 0, mk(1, 1, 0, 0, 0, 5'b10101, 1, 1, 0, 0, 0, 0, 0));
    vecs[9]  = v(1'b1, OP_SLTI, 0, 10, 0, 0, mk(1, 1, 0, 0, 0, 5'b11001, 1, 1, 0, 0, 1, 1, 6));
    vecs[10] = v(1'b1, OP_MUL,  0, 0, 11, 0, mk(1, 1, 0, 0, 0, 5'b11101, 1, 0, 0, 0, 1, 1, 7));
    vecs[11] = v(1'b1, OP_SW,   0, 12, 0, 0, mk(1, 1, 0, 0, 0, 5'b00011, 0, 0, 0, 0, 1, 1, 9));
    vecs[12] = v(1'b1, OP_LW,   0, 13, 0, 0, mk(1, 1, 0, 0, 0, 5'b00001, 1, 0, 0, 0, 1, 1, 10));
    vecs[13] = v(1'b1, OP_NOP,  0, 0,  0, 0, mk(1, 1, 0, 0, 0, 5'b00001, 1, 0, 0, 1, 1, 1, 11));
    vecs[14] = v(1'b1, OP_J,    0, 0,  0, 0, mk(1, 1, 1, 0, 1, 5'b00000, 0, 0, 1, 0, 0, 0, 12));
    vecs[15] = v(1'b1, OP_NOP,  0, 0,  0, 0, mk(1, 1, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 1, 0, 13));
    vecs[16] = v(1'b1, OP_BEQ,  0, 0,  0, 0, mk(1, 1, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 0, 0));
    vecs[17] = v(1'b1, OP_NOP,  0, 0,  0, 1, mk(1, 1, 1, 1, 0, 5'b00010, 0, 0, 0, 0, 0, 0, 0));
    vecs[18] = v(1'b1, OP_NOP,  0, 0,  0, 1, mk(1, 1, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 0, 0));
    vecs[19] = v(1'b1, OP_BNE,  0, 0,  0, 1, mk(1, 1, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 0, 0));
    vecs[20] = v(1'b1, OP_NOP,  0, 0,  0, 1, mk(1, 1, 0, 0, 0, 5'b00010, 0, 0, 0, 0, 0, 0, 0));
    vecs[21] = v(1'b1, OP_NOP,  0, 0,  0, 0, mk(1, 1, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i].rst, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].zero);
      chk($sformatf("vec%0d", i), 32'(got), 32'(vecs[i].exp));
    end

    // Load-use: lw r8, then a consumer of r8.
    apply(1, OP_LW, 0, 8, 0, 0);
    chk("lu_pcw_before", 32'(PCWrite), 1);
    apply(1, OP_R, 8, 0, 20, 0);
    chk("lu_pcw_stall", 32'(PCWrite), 0);
    chk("lu_ifw_stall", 32'(IFIDWrite), 0);
    apply(1, OP_R, 8, 0, 20, 0);
    chk("lu_ex_aluop_bubble", 32'(EX_ALUOp), 0);
    chk("lu_ex_alusrc_bubble", 32'(EX_ALUSrc), 0);
    chk("lu_pcw_second", 32'(PCWrite), FWD);
`ifdef PCU_FORWARD_EN
    apply(1, OP_NOP, 0, 0, 0, 0);
    chk("lu_fwd_a_wb", 32'(ForwardA), 1);
`else
    apply(1, OP_R, 8, 0, 20, 0);
`endif
    chk("lu_pcw_released", 32'(PCWrite), 1);

    // Taken branch in EX while a RAW hazard is present in ID.
    apply(1, OP_R, 0, 0, 4, 0);
    apply(1, OP_BEQ, 0, 0, 0, 0);
    apply(1, OP_R, 4, 0, 21, 1);
    chk("bos_pcsrc", 32'(PCSrc), 1);
    chk("bos_flush", 32'(IFIDFlush), 1);
    chk("bos_pcw", 32'(PCWrite), 1);
    chk("bos_ifw", 32'(IFIDWrite), 1);
    apply(1, OP_NOP, 0, 0, 0, 1);
    chk("bos_ex_bubble", 32'(EX_ALUOp), 0);
    chk("bos_pcsrc_after", 32'(PCSrc), 0);

    // Jump held off by a stall, then taken.
    apply(1, OP_LW, 0, 14, 0, 0);
    apply(1, OP_J, 14, 0, 0, 0);
    chk("js_jump_stalled", 32'(Jump), 0);
    chk("js_flush_stalled", 32'(IFIDFlush), 0);
    chk("js_pcw_stalled", 32'(PCWrite), 0);
    apply(1, OP_J, 14, 0, 0, 0);
    chk("js_jump_second", 32'(Jump), FWD);
`ifndef PCU_FORWARD_EN
    apply(1, OP_J, 14, 0, 0, 0);
    chk("js_jump_third", 32'(Jump), 1);
    chk("js_flush_third", 32'(IFIDFlush), 1);
`endif
    apply(1, OP_NOP, 0, 0, 0, 0);

    // ALU-result RAW: add r3, then consumers of r3.
    apply(1, OP_R, 0, 0, 3, 0);
`ifdef PCU_FORWARD_EN
    apply(1, OP_R, 3, 0, 22, 0);
    chk("raw_pcw", 32'(PCWrite), 1);
    apply(1, OP_R, 3, 3, 23, 0);
    chk("raw_fwd_a_mem", 32'(ForwardA), 2);
    chk("raw_fwd_b_none", 32'(ForwardB), 0);
    apply(1, OP_NOP, 0, 0, 0, 0);
    chk("raw_fwd_a_wb", 32'(ForwardA), 1);
    chk("raw_fwd_b_wb", 32'(ForwardB), 1);
`else
    apply(1, OP_R, 3, 0, 22, 0);
    chk("raw_stall1", 32'(PCWrite), 0);
    apply(1, OP_R, 3, 0, 22, 0);
    chk("raw_stall2", 32'(PCWrite), 0);
    apply(1, OP_R, 3, 0, 22, 0);
    chk("raw_release", 32'(PCWrite), 1);
    chk("raw_fwd_a_tied", 32'(ForwardA), 0);
`endif

    // Reset asserted while a load-use stall is pending.
    apply(1, OP_LW, 0, 15, 0, 0);
    apply(0, OP_R, 15, 0, 24, 0);
    chk("rst_pcw_forced", 32'(PCWrite), 0);
    chk("rst_ifw_forced", 32'(IFIDWrite), 0);
    chk("rst_pcsrc_forced", 32'(PCSrc), 0);
    apply(1, OP_R, 15, 0, 24, 0);
    chk("rst_after_pcw", 32'(PCWrite), 1);
    chk("rst_after_ifw", 32'(IFIDWrite), 1);
    chk("rst_after_aluop", 32'(EX_ALUSrc), 0);
    chk("rst_after_wbrw", 32'(WB_RegWrite), 0);
    chk("rst_after_wreg", 32'(WB_WriteReg), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Successor to the single-cycle opcode decoder for the SAD pipelined datapath.
- Decodes the ID-stage opcode into a control bundle and carries it through the ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use and RAW hazards and issues stalls and bubbles.
- Resolves branches in EX and drives PC/IF-ID steering. Width-parametrised; forwarding is a build option.

Parameters:
- ALUOP_W, 5: width of the ALUOp field.
- REG_W, 5: register-address width.
- OPC_W, 6: opcode width.

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  synchronous, active-low reset
- ID_Opcode  in  OPC_W  opcode of the instruction in IF/ID
- ID_Rs  in  REG_W  source register of the IF/ID instruction
- ID_Rt  in  REG_W  second source register of the IF/ID instruction
- ID_Rd  in  REG_W  destination field of the IF/ID instruction
- EX_Zero  in  1  ALU zero flag of the instruction in EX
- PCWrite  out  1  PC update enable
- IFIDWrite  out  1  IF/ID register enable
- IFIDFlush  out  1  zero the IF/ID register at the next edge
- PCSrc  out  1  select branch target
- Jump  out  1  select jump target
- EX_ALUOp  out  ALUOP_W  EX-stage ALU operation
- EX_ALUSrc  out  1  EX-stage ALU B-input select
- EX_ZeroExt  out  1  EX-stage immediate zero-extend select
- MEM_MemRead  out  1  MEM-stage read enable
- MEM_MemWrite  out  1  MEM-stage write enable
- WB_RegWrite  out  1  WB-stage register write enable
- WB_MemToReg  out  1  WB select; 1 = ALU result, 0 = memory data
- WB_WriteReg  out  REG_W  WB destination register
- ForwardA  out  2  forward select for ALU operand A
- ForwardB  out  2  forward select for ALU operand B

Behaviour:
- Decode is combinational in ID. All other fields 0 unless listed.
  - 000000 R: RegWrite, RegDst, MemToReg=1; ALUOp 00000.
  - 001000 addi: RegWrite, ALUSrc, MemToReg=1; ALUOp 00001.
  - 011100 mul: RegWrite, RegDst, MemToReg=1; ALUOp 00011.
  - 001100 andi: RegWrite, ALUSrc, MemToReg, ZeroExt; ALUOp 10100.
  - 001101 ori: as andi; ALUOp 10101.
  - 001110 xori: as andi; ALUOp 11001.
  - 001010 slti: RegWrite, ALUSrc, MemToReg=1; ALUOp 11101.
  - 100011 lw: RegWrite, ALUSrc, MemRead, MemToReg=0; ALUOp 00001.
  - 101011 sw: ALUSrc, MemWrite; ALUOp 00001.
  - 000100 beq: Branch, BrNe=0; ALUOp 00010.
  - 000101 bne: Branch, BrNe=1; ALUOp 00010.
  - 000010 j: Jump only.
  - Any other opcode decodes to an all-zero bundle (NOP).
- ALUOp constants are zero-extended or truncated to ALUOP_W.
- Destination register: ID_Rd if RegDst, else ID_Rt. It is captured into ID/EX together with ID_Rs and ID_Rt. Register 0 never counts as a hazard or forwarding match.
- Pipeline: ID/EX, EX/MEM and MEM/WB registers all update every edge. Each stage's outputs are read directly from its own register.
- Branch taken: EX_Branch & (EX_Zero ^ EX_BrNe).
  - PCSrc=1 combinationally in that same cycle.
  - IFIDFlush=1 in that same cycle.
  - At the next edge, ID/EX loads a bubble.
- Jump: Jump=1 combinationally while j is in ID; IFIDFlush=1. The j bundle itself travels as a NOP.
- Load-use stall, active when EX_MemRead & EX_Dst≠0 & (EX_Dst==ID_Rs | EX_Dst==ID_Rt):
  - PCWrite=0 and IFIDWrite=0.
  - ID/EX loads a bubble. The stall lasts exactly 1 cycle.
- Priority: taken branch > stall > jump.
  - A taken branch overrides a stall: PCWrite=1, IFIDFlush=1.
  - Jump is ignored while stalled; it is re-evaluated the next cycle.
- Default outputs with no event: PCWrite=1, IFIDWrite=1, IFIDFlush=0.
- Reset (Rst=0 at an edge): all pipeline control registers are cleared to bubble, which drives every EX/MEM/WB output and WB_WriteReg to 0.
  - PCWrite, IFIDWrite, IFIDFlush, PCSrc and Jump are forced to 0 while Rst=0.
  - Reset asserted mid-stall or mid-flush aborts it; the first post-reset cycle has no hazard.

Optional Feature:
- Macro: PCU_FORWARD_EN.
- Defined:
  - ForwardA/B = 10 when MEM_RegWrite & MEM_Dst≠0 & MEM_Dst==EX_Rs/EX_Rt.
  - Otherwise 01 when the WB stage matches the same way.
  - Otherwise 00. The MEM stage has priority over WB.
  - Only load-use causes a stall.
- Undefined:
  - ForwardA/B are tied to 00.
  - A stall is also raised when ID_Rs or ID_Rt matches a nonzero EX_Dst or MEM_Dst whose RegWrite=1. The stall repeats until the producer reaches WB, so register-file write-before-read is required.

Test Plan:
- Reset: hold Rst=0 for 2 cycles with ID_Opcode=000000 → all outputs 0. Release → PCWrite=1, IFIDWrite=1.
- Decode and pipelining: issue addi (001000) with Rt=5 → 1 cycle later EX_ALUOp=00001, EX_ALUSrc=1. 3 cycles later WB_RegWrite=1, WB_WriteReg=5, WB_MemToReg=1.
- Load-use: lw Rt=8, then add with Rs=8 → exactly 1 cycle of PCWrite=0, IFIDWrite=0; the next EX bundle is all 0.
- Branch: beq in EX with EX_Zero=1 → PCSrc=1, IFIDFlush=1; next EX bundle is a bubble. The same case with bne → PCSrc=0, no flush.
- Branch over stall: taken beq in EX while a load-use condition is present in ID → PCWrite=1, IFIDFlush=1.
- Forwarding (PCU_FORWARD_EN): add Rd=3, then sub Rs=3 → ForwardA=10. A second consumer two instructions later → ForwardA=01. Without the macro → 2 stall cycles and ForwardA=00.
